// File: rtl/stage_fetch_pkg.sv
// Shared definitions for the fetch stage: datapath width, reset/bubble constants,
// next-PC select encodings and fetch FSM states.
package stage_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;

  // 2'b11 is treated as a jump as well
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_fetch_pc_sel.sv
// Next-PC selection: sequential +4 (wrapping) or a decode-supplied jump/branch target.
module fetch_pc_sel
  import stage_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pcF,
  input  logic [1:0]      pc_selD,
  input  logic [XLEN-1:0] branch_result,
  input  logic [XLEN-1:0] jump_result,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pcF + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_selD)
      PC_PLUS4:  next_pc = pc_plus4;
      PC_BRANCH: next_pc = branch_result;
      default:   next_pc = jump_result;
    endcase
  end

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: owns pcF, drives the 1-cycle-latency instruction memory and keeps
// instrD stable across stalls through a hold register.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   FETCH_BOOT  | first cycle after reset; RESET_PC read issued, bubble out
//   FETCH_RUN   | imem_rdata is the word at pcF, presented straight to decode
//   FETCH_STALL | memory disabled; decode sees the captured hold_instr
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            flushD,
  input  logic [1:0]      pc_selD,
  input  logic [XLEN-1:0] branch_result,
  input  logic [XLEN-1:0] jump_result,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic            validD
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pcF, pc_nxt;
  logic [XLEN-1:0] hold_instr, hold_nxt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] fetch_addr;

  fetch_pc_sel u_pc_sel (
    .pcF           (pcF),
    .pc_selD       (pc_selD),
    .branch_result (branch_result),
    .jump_result   (jump_result),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_BOOT;
      pcF        <= RESET_PC;
      hold_instr <= NOP;
    end else begin
      state      <= state_nxt;
      pcF        <= pc_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pcF;
    hold_nxt   = hold_instr;
    fetch_addr = pcF;
    imem_en    = 1'b1;
    instrD     = NOP;
    pcD        = pcF;
    validD     = 1'b0;

    case (state)
      FETCH_BOOT: begin
        pcD       = RESET_PC;
        state_nxt = FETCH_RUN;
      end

      FETCH_RUN, FETCH_STALL: begin
        instrD = (state == FETCH_RUN) ? imem_rdata : hold_instr;
        validD = 1'b1;
        if (flushD) begin
          // flush beats stall: kill the decode slot and take the redirect now
          instrD     = NOP;
          validD     = 1'b0;
          fetch_addr = next_pc;
          pc_nxt     = next_pc;
          hold_nxt   = NOP;
          state_nxt  = FETCH_RUN;
        end else if (stallF) begin
          imem_en = 1'b0;
          if (state == FETCH_RUN) begin
            hold_nxt  = imem_rdata;
            state_nxt = FETCH_STALL;
          end
        end else begin
          fetch_addr = next_pc;
          pc_nxt     = next_pc;
          state_nxt  = FETCH_RUN;
        end
      end

      default: begin
        state_nxt = FETCH_BOOT;
      end
    endcase
  end

  assign imem_addr = word_align(fetch_addr);

endmodule

// File: tb/tb_stage_fetch.sv
// Directed scoreboard bench for stage_fetch with a 1-cycle-latency memory model.
module tb_stage_fetch;

  localparam logic [31:0] RST_PC  = 32'h4000_0000;
  localparam logic [31:0] NOP_W   = 32'h0000_0013;
  localparam logic [31:0] BOOT_W  = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, flushD;
  logic [1:0]  pc_selD;
  logic [31:0] branch_result, jump_result;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] instrD, pcD;
  logic        validD;
  logic        scramble;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        en;
    logic [31:0] addr;
    logic        chk_addr;
  } exp_t;

  exp_t exp_q[$];

  stage_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .flushD        (flushD),
    .pc_selD       (pc_selD),
    .branch_result (branch_result),
    .jump_result   (jump_result),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .instrD        (instrD),
    .pcD           (pcD),
    .validD        (validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return BOOT_W;
    return a ^ 32'h1234_5678;
  endfunction

  // synchronous memory; output garbage while disabled if scramble is set
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
    else if (scramble) imem_rdata <= $urandom;
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid, input logic en,
                              input logic [31:0] addr, input logic chk_addr);
    exp_t e;
    e.pc = pc; e.instr = instr; e.valid = valid;
    e.en = en; e.addr = addr; e.chk_addr = chk_addr;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sample(input string tag, input exp_t e);
    exp_t got_e;
    exp_q.push_back(e);
    #3;
    got_e = exp_q.pop_front();
    chk({tag, ".instrD"}, instrD, got_e.instr);
    chk({tag, ".pcD"}, pcD, got_e.pc);
    chk({tag, ".validD"}, {31'd0, validD}, {31'd0, got_e.valid});
    chk({tag, ".imem_en"}, {31'd0, imem_en}, {31'd0, got_e.en});
    if (got_e.chk_addr) chk({tag, ".imem_addr"}, imem_addr, got_e.addr);
  endtask

  task automatic step(input string tag, input logic st, input logic fl,
                      input logic [1:0] sel, input logic [31:0] tgt, input exp_t e);
    @(posedge clk);
    #1;
    stallF = st; flushD = fl; pc_selD = sel;
    branch_result = tgt; jump_result = tgt ^ 32'h0000_1000;
    if (sel != 2'b10) begin
      jump_result = tgt; branch_result = tgt ^ 32'h0000_1000;
    end
    sample(tag, e);
  endtask

  function automatic logic [31:0] pa(input logic [11:0] off);
    return RST_PC + {20'd0, off};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stallF = 1'b0; flushD = 1'b0; pc_selD = 2'b00;
    branch_result = '0; jump_result = '0; scramble = 1'b0;
    #12;
    sample("reset", mk(RST_PC, NOP_W, 1'b0, 1'b1, RST_PC, 1'b1));

    @(posedge clk); #1; rst = 1'b0;
    sample("boot", mk(RST_PC, NOP_W, 1'b0, 1'b1, RST_PC, 1'b1));

    step("run0", 0, 0, 2'b00, 0, mk(pa(12'h000), BOOT_W, 1, 1, pa(12'h004), 1));
    step("run1", 0, 0, 2'b00, 0, mk(pa(12'h004), mem_word(pa(12'h004)), 1, 1, pa(12'h008), 1));
    scramble = 1'b1;
    step("stl0", 1, 0, 2'b00, 0, mk(pa(12'h008), mem_word(pa(12'h008)), 1, 0, 0, 0));
    step("stl1", 1, 0, 2'b00, 0, mk(pa(12'h008), mem_word(pa(12'h008)), 1, 0, 0, 0));
    step("stl2", 1, 0, 2'b10, pa(12'h700), mk(pa(12'h008), mem_word(pa(12'h008)), 1, 0, 0, 0));
    step("rel",  0, 0, 2'b00, 0, mk(pa(12'h008), mem_word(pa(12'h008)), 1, 1, pa(12'h00C), 1));
    step("run2", 0, 0, 2'b00, 0, mk(pa(12'h00C), mem_word(pa(12'h00C)), 1, 1, pa(12'h010), 1));
    step("run3", 0, 0, 2'b00, 0, mk(pa(12'h010), mem_word(pa(12'h010)), 1, 1, pa(12'h014), 1));
    step("br",   0, 0, 2'b10, pa(12'h100), mk(pa(12'h014), mem_word(pa(12'h014)), 1, 1, pa(12'h100), 1));
    step("brtgt",0, 0, 2'b00, 0, mk(pa(12'h100), mem_word(pa(12'h100)), 1, 1, pa(12'h104), 1));
    step("j11",  0, 0, 2'b11, pa(12'h300), mk(pa(12'h104), mem_word(pa(12'h104)), 1, 1, pa(12'h300), 1));
    step("jstl", 1, 0, 2'b01, pa(12'h500), mk(pa(12'h300), mem_word(pa(12'h300)), 1, 0, 0, 0));
    step("sflush", 1, 1, 2'b01, pa(12'h200), mk(pa(12'h300), NOP_W, 0, 1, pa(12'h200), 1));
    step("jtgt", 0, 0, 2'b00, 0, mk(pa(12'h200), mem_word(pa(12'h200)), 1, 1, pa(12'h204), 1));
    step("rflush", 0, 1, 2'b00, 0, mk(pa(12'h204), NOP_W, 0, 1, pa(12'h208), 1));
    step("after_fl", 1, 0, 2'b00, 0, mk(pa(12'h208), mem_word(pa(12'h208)), 1, 0, 0, 0));
    step("stl3", 1, 0, 2'b00, 0, mk(pa(12'h208), mem_word(pa(12'h208)), 1, 0, 0, 0));

    #1; rst = 1'b1;
    sample("async_rst", mk(RST_PC, NOP_W, 0, 1, RST_PC, 1));
    @(posedge clk); #1; rst = 1'b0; stallF = 1'b0;
    sample("reboot", mk(RST_PC, NOP_W, 0, 1, RST_PC, 1));
    step("rerun0", 0, 0, 2'b01, 32'hFFFF_FFFC, mk(RST_PC, BOOT_W, 1, 1, 32'hFFFF_FFFC, 1));
    step("wrap", 0, 0, 2'b00, 0, mk(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1, 1, 32'h0000_0000, 1));
    step("zero", 0, 0, 2'b01, 32'h4000_0402, mk(32'h0000_0000, mem_word(32'h0000_0000), 1, 1, 32'h4000_0400, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
